// File: rtl/nvdla_tcdm_bridge.sv
// nvdla_tcdm_bridge: per-port TCDM master with a request slice, read credits and a response FIFO
module nvdla_tcdm_bridge #(
  parameter int MP    = 3,
  parameter int DW    = 32,
  parameter int AW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic [MP-1:0]            in_req,
  output logic [MP-1:0]            in_gnt,
  input  logic [MP-1:0][AW-1:0]    in_add,
  input  logic [MP-1:0]            in_wen,
  input  logic [MP-1:0][DW/8-1:0]  in_be,
  input  logic [MP-1:0][DW-1:0]    in_data,
  output logic [MP-1:0]            in_r_valid,
  input  logic [MP-1:0]            in_r_ready,
  output logic [MP-1:0][DW-1:0]    in_r_data,
  output logic [MP-1:0]            tcdm_req,
  input  logic [MP-1:0]            tcdm_gnt,
  output logic [MP-1:0][AW-1:0]    tcdm_add,
  output logic [MP-1:0]            tcdm_wen,
  output logic [MP-1:0][DW/8-1:0]  tcdm_be,
  output logic [MP-1:0][DW-1:0]    tcdm_data,
  input  logic [MP-1:0]            tcdm_r_valid,
  input  logic [MP-1:0][DW-1:0]    tcdm_r_data,
  output logic [MP-1:0]            busy_o
);
  localparam int BW = DW / 8;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic clr;
  assign clr = rst_i | clear_i;
  for (genvar g = 0; g < MP; g++) begin : g_port
    logic          slot_valid, slot_wen, rd_pend, fire, load, push, pop, rd_fire, empty;
    logic [AW-1:0] slot_add;
    logic [BW-1:0] slot_be;
    logic [DW-1:0] slot_data;
    logic [CW-1:0] cnt, rptr, wptr;
    logic [DW-1:0] mem [DEPTH];
    assign fire          = tcdm_req[g] & tcdm_gnt[g];
    assign in_gnt[g]     = !clr & (!slot_valid | fire);
    assign load          = in_req[g] & in_gnt[g];
    // a read may only issue while a FIFO slot is reserved for its response
    assign tcdm_req[g]   = slot_valid & (!slot_wen | (cnt < CW'(DEPTH)));
    assign tcdm_add[g]   = slot_add;
    assign tcdm_wen[g]   = slot_wen;
    assign tcdm_be[g]    = slot_be;
    assign tcdm_data[g]  = slot_data;
    assign rd_fire       = fire & slot_wen;
    assign push          = tcdm_r_valid[g] & rd_pend;
    assign empty         = rptr == wptr;
    assign pop           = in_r_valid[g] & in_r_ready[g];
    assign in_r_valid[g] = !empty;
    assign in_r_data[g]  = empty ? '0 : mem[rptr[PW-1:0]];
    assign busy_o[g]     = slot_valid | rd_pend | !empty;
    always_ff @(posedge clk_i) begin
      if (clr) begin
        slot_valid <= 1'b0;
        slot_wen   <= 1'b0;
        slot_add   <= '0;
        slot_be    <= '0;
        slot_data  <= '0;
        rd_pend    <= 1'b0;
        cnt        <= '0;
        rptr       <= '0;
        wptr       <= '0;
      end else begin
        if (load) begin
          slot_valid <= 1'b1;
          slot_wen   <= in_wen[g];
          slot_add   <= in_add[g];
          slot_be    <= in_be[g];
          slot_data  <= in_data[g];
        end else if (fire) begin
          slot_valid <= 1'b0;
        end
        rd_pend <= rd_fire;
        cnt     <= cnt + CW'(rd_fire) - CW'(pop);
        wptr    <= wptr + CW'(push);
        rptr    <= rptr + CW'(pop);
      end
    end
    always_ff @(posedge clk_i) begin
      if (push) mem[wptr[PW-1:0]] <= tcdm_r_data[g];
    end
  end
endmodule

// File: tb/tb_nvdla_tcdm_bridge.sv
// tb_nvdla_tcdm_bridge: random + directed scoreboard bench against a transaction-level model
module tb_nvdla_tcdm_bridge;
  localparam int MP = 3, DW = 32, AW = 32, DEPTH = 4, BW = DW / 8;
  typedef struct {bit v; bit rd; logic [AW-1:0] add; logic [BW-1:0] be; logic [DW-1:0] data;} slot_t;
  typedef struct {int p; logic [DW-1:0] d;} exp_t;
  logic clk = 0, rst_i = 1, clear_i = 0;
  logic [MP-1:0] in_req = '0, in_gnt, in_wen = '0, in_r_valid, in_r_ready = '0;
  logic [MP-1:0] tcdm_req, tcdm_gnt = '0, tcdm_wen, tcdm_r_valid = '0, busy_o;
  logic [MP-1:0][AW-1:0] in_add = '0, tcdm_add;
  logic [MP-1:0][BW-1:0] in_be = '0, tcdm_be;
  logic [MP-1:0][DW-1:0] in_data = '0, in_r_data, tcdm_data, tcdm_r_data = '0;
  int tests = 0, fails = 0;
  slot_t sm[MP];
  int outs[MP], occ[MP], dut_fire[MP], dut_acc[MP];
  bit pend[MP], rv_next[MP], acc_last[MP];
  logic [DW-1:0] rd_next[MP];
  logic [DW-1:0] tmem[MP][64], rmem[MP][64];
  exp_t expq[$];
  bit d_rst = 1, d_clr = 0, spur = 0;
  logic [MP-1:0] d_req = '0, d_wen = '0, d_gnt = '1, d_rdy = '0;
  logic [AW-1:0] d_add[MP];
  logic [BW-1:0] d_be[MP];
  logic [DW-1:0] d_data[MP];

  always #5 clk = ~clk;

  nvdla_tcdm_bridge #(.MP(MP), .DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i),
    .in_req(in_req), .in_gnt(in_gnt), .in_add(in_add), .in_wen(in_wen), .in_be(in_be), .in_data(in_data),
    .in_r_valid(in_r_valid), .in_r_ready(in_r_ready), .in_r_data(in_r_data),
    .tcdm_req(tcdm_req), .tcdm_gnt(tcdm_gnt), .tcdm_add(tcdm_add), .tcdm_wen(tcdm_wen), .tcdm_be(tcdm_be),
    .tcdm_data(tcdm_data), .tcdm_r_valid(tcdm_r_valid), .tcdm_r_data(tcdm_r_data), .busy_o(busy_o)
  );

  task automatic chk(string name, int p, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s port %0d: got %0h expected %0h", name, p, act, exp);
    end
  endtask

  // one clock cycle: drive at negedge, check model predictions, advance the model across the edge
  task automatic step();
    bit er, eg, acc, fire, pop;
    int i;
    @(negedge clk);
    rst_i = d_rst;
    clear_i = d_clr;
    for (int p = 0; p < MP; p++) begin
      in_req[p] = d_req[p]; in_wen[p] = d_wen[p]; in_add[p] = d_add[p]; in_be[p] = d_be[p];
      in_data[p] = d_data[p]; tcdm_gnt[p] = d_gnt[p]; in_r_ready[p] = d_rdy[p];
      tcdm_r_valid[p] = rv_next[p] | (spur && $urandom_range(0, 5) == 0);
      tcdm_r_data[p] = rd_next[p];
    end
    #1;
    for (int p = 0; p < MP; p++) begin
      er = sm[p].v && (!sm[p].rd || outs[p] < DEPTH);
      eg = !rst_i && !clear_i && (!sm[p].v || (er && tcdm_gnt[p]));
      chk("in_gnt", p, in_gnt[p], eg);
      chk("tcdm_req", p, tcdm_req[p], er);
      chk("in_r_valid", p, in_r_valid[p], occ[p] > 0);
      chk("busy", p, busy_o[p], sm[p].v || pend[p] || occ[p] > 0);
      if (er) begin
        chk("tcdm_add", p, tcdm_add[p], sm[p].add);
        chk("tcdm_cmd", p, {tcdm_wen[p], tcdm_be[p], tcdm_data[p]}, {sm[p].rd, sm[p].be, sm[p].data});
      end
      dut_fire[p] += int'(tcdm_req[p] & tcdm_gnt[p]);
      dut_acc[p] += int'(in_req[p] & in_gnt[p]);
      fire = er && tcdm_gnt[p];
      acc = in_req[p] && eg;
      pop = occ[p] > 0 && in_r_ready[p];
      acc_last[p] = acc;
      rv_next[p] = fire;
      rd_next[p] = $urandom;
      if (fire) begin
        i = int'(sm[p].add[7:2]);
        if (sm[p].rd) rd_next[p] = tmem[p][i];
        else for (int b = 0; b < BW; b++) if (sm[p].be[b]) tmem[p][i][8*b+:8] = sm[p].data[8*b+:8];
      end
      if (rst_i || clear_i) begin
        sm[p].v = 0; outs[p] = 0; occ[p] = 0; pend[p] = 0;
      end else begin
        if (pend[p] && tcdm_r_valid[p]) occ[p]++;
        if (pop) begin occ[p]--; outs[p]--; end
        if (fire && sm[p].rd) outs[p]++;
        pend[p] = fire && sm[p].rd;
        if (acc) begin
          sm[p] = '{1'b1, in_wen[p], in_add[p], in_be[p], in_data[p]};
          i = int'(in_add[p][7:2]);
          if (in_wen[p]) expq.push_back('{p, rmem[p][i]});
          else for (int b = 0; b < BW; b++) if (in_be[p][b]) rmem[p][i][8*b+:8] = in_data[p][8*b+:8];
        end else if (fire) sm[p].v = 0;
      end
    end
    if (rst_i || clear_i) begin
      expq.delete();
      rmem = tmem;
    end
  endtask

  // response monitor: every upstream pop must match the oldest expected read of that port
  always @(negedge clk) begin
    int k;
    #1;
    if (!rst_i && !clear_i)
      for (int p = 0; p < MP; p++)
        if (in_r_valid[p] && in_r_ready[p]) begin
          k = -1;
          foreach (expq[j]) if (k < 0 && expq[j].p == p) k = j;
          tests++;
          if (k < 0) begin
            fails++;
            $display("FAIL rdata_unexpected port %0d: got %0h expected no response", p, in_r_data[p]);
          end else begin
            if (in_r_data[p] !== expq[k].d) begin
              fails++;
              $display("FAIL rdata port %0d: got %0h expected %0h", p, in_r_data[p], expq[k].d);
            end
            expq.delete(k);
          end
        end
  end

  task automatic set_op(int p, bit rd, int idx);
    d_req[p] = 1; d_wen[p] = rd; d_add[p] = 32'h100 + 32'(idx) * 4;
    d_be[p] = rd ? 4'hF : 4'($urandom); d_data[p] = $urandom;
  endtask

  task automatic send(int p, bit rd, int idx);
    set_op(p, rd, idx);
    for (int n = 0; n < 50; n++) begin
      step();
      if (acc_last[p]) break;
    end
    chk("send_accept", p, acc_last[p], 1);
    d_req[p] = 0;
  endtask

  task automatic rand_port(int p);
    if (!d_req[p] || acc_last[p]) begin
      if ($urandom_range(0, 2) != 0) set_op(p, 1'($urandom_range(0, 1)), $urandom_range(0, 63));
      else d_req[p] = 0;
    end
  endtask

  task automatic drain(int n);
    d_req = '0; d_gnt = '1; d_rdy = '1;
    repeat (n) step();
  endtask

  task automatic single_read(int p, int idx, logic [DW-1:0] v);
    tmem[p][idx] = v; rmem[p][idx] = v; d_gnt[p] = 1; d_rdy[p] = 1;
    set_op(p, 1, idx);
    step(); chk("lat_accept", p, acc_last[p], 1); d_req[p] = 0;
    step(); chk("lat_tcdm_req", p, tcdm_req[p], 1);
    step();
    step(); chk("lat_r_valid", p, in_r_valid[p], 1); chk("lat_r_data", p, in_r_data[p], v);
    step(); chk("lat_idle", p, busy_o[p], 0);
  endtask

  initial begin
    int f0, a0;
    for (int p = 0; p < MP; p++) begin
      d_add[p] = 0; d_be[p] = 0; d_data[p] = 0; rd_next[p] = 0;
      for (int i = 0; i < 64; i++) tmem[p][i] = $urandom;
    end
    rmem = tmem;
    step(); step();
    d_rst = 0;
    step();
    for (int p = 0; p < MP; p++) begin
      chk("rst_tcdm_add", p, tcdm_add[p], 0);
      chk("rst_tcdm_data", p, tcdm_data[p], 0);
      chk("rst_r_data", p, in_r_data[p], 0);
    end
    single_read(0, 0, 32'hDEADBEEF);
    // credit stall: 4 reads outstanding with no pops blocks the 5th
    d_rdy = '0; f0 = dut_fire[0];
    for (int i = 1; i <= 5; i++) send(0, 1, i);
    repeat (3) step();
    chk("credit_grants", 0, dut_fire[0] - f0, 4);
    chk("credit_stall", 0, tcdm_req[0], 0);
    d_rdy[0] = 1; step(); d_rdy[0] = 0;
    step(); chk("credit_resume", 0, tcdm_req[0], 1);
    send(0, 1, 6);
    drain(15);
    // full FIFO, then a write stream that must not be throttled
    d_rdy = '0;
    for (int i = 7; i <= 10; i++) send(0, 1, i);
    repeat (3) step();
    a0 = dut_acc[0]; f0 = dut_fire[0];
    for (int i = 0; i < 8; i++) begin set_op(0, 0, $urandom_range(0, 63)); step(); end
    d_req[0] = 0; step();
    chk("write_accepts", 0, dut_acc[0] - a0, 8);
    chk("write_grants", 0, dut_fire[0] - f0, 8);
    chk("write_fifo_full", 0, in_r_valid[0], 1);
    drain(12);
    // port 0 starved of grants while ports 1 and 2 stream
    d_gnt = 3'b110; d_rdy = '1;
    set_op(0, 1, 30);
    for (int i = 0; i < 6; i++) begin
      rand_port(1); rand_port(2);
      step();
      if (i == 0) d_req[0] = 0;
      else chk("starve_gnt", 0, in_gnt[0], 0);
    end
    drain(12);
    // reset with reads in flight and one firing in the reset cycle
    d_rdy = '0;
    send(0, 1, 10); send(0, 1, 11);
    set_op(0, 1, 12); step(); d_req[0] = 0;
    d_rst = 1; step(); d_rst = 0;
    step();
    chk("rst_tcdm_req", 0, tcdm_req[0], 0);
    chk("rst_r_valid", 0, in_r_valid[0], 0);
    chk("rst_busy", 0, busy_o[0], 0);
    step();
    single_read(0, 20, $urandom);
    // random traffic with spurious responses and occasional clears
    spur = 1;
    for (int n = 0; n < 3000; n++) begin
      for (int p = 0; p < MP; p++) begin
        rand_port(p);
        d_gnt[p] = $urandom_range(0, 3) != 0;
        d_rdy[p] = $urandom_range(0, 1);
      end
      d_clr = $urandom_range(0, 399) == 0;
      step();
    end
    d_clr = 0; spur = 0;
    drain(30);
    chk("drain_empty", 0, expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/nvdla_tcdm_bridge.md
# nvdla_tcdm_bridge

Parametrised multi-port TCDM master bridge between the NVDLA HWPE datapath and the cluster TCDM interconnect. Each of the MP ports gets a one-entry request register slice, in-flight read credit tracking, and a response FIFO. Together these add response backpressure, which raw TCDM ports lack, and drop write responses. It sits between the accelerator engine and the flattened `tcdm_*` master ports of the top wrapper.

## Interface
- MP, 3, number of independent TCDM ports
- DW, 32, data width (multiple of 8); BE width is DW/8
- AW, 32, address width
- DEPTH, 4, response FIFO entries and max in-flight reads per port (power of 2, >=2)

- clk_i  in  1  single clock; all logic rising-edge
- rst_i  in  1  reset, synchronous, active-high
- clear_i  in  1  synchronous soft clear; same effect as rst_i
- in_req  in  [MP]  upstream request valid
- in_gnt  out  [MP]  upstream request accepted this cycle
- in_add  in  [MP][AW]  byte address
- in_wen  in  [MP]  1 = read, 0 = write
- in_be  in  [MP][DW/8]  byte enables
- in_data  in  [MP][DW]  write data
- in_r_valid  out  [MP]  read response available
- in_r_ready  in  [MP]  upstream consumes response
- in_r_data  out  [MP][DW]  read data (FIFO head)
- tcdm_req  out  [MP]  TCDM request
- tcdm_gnt  in  [MP]  TCDM grant
- tcdm_add/tcdm_wen/tcdm_be/tcdm_data  out  [MP][AW]/[MP]/[MP][DW/8]/[MP][DW]  TCDM request fields
- tcdm_r_valid  in  [MP]  TCDM response, exactly 1 cycle after each grant
- tcdm_r_data  in  [MP][DW]  TCDM read data
- busy_o  out  [MP]  port has buffered request, read in flight, or FIFO non-empty

## Operation
- Ports are fully independent. Everything below applies per port p.
- Slot: one register {valid, add, wen, be, data}.
  - `fire = tcdm_req & tcdm_gnt`.
  - `in_gnt = !rst_i & !clear_i & (!slot_valid | fire)`. This is combinational from tcdm_gnt.
  - When `in_req & in_gnt`, the slot loads and stays valid. Otherwise `fire` clears valid.
- Issue: `tcdm_req = slot_valid & (slot_wen == 0 | cnt < DEPTH)`. tcdm_add/wen/be/data are driven directly from the slot.
  - Once tcdm_req is asserted, it and all fields stay stable until granted. cnt cannot increase while the slot waits, so this holds.
- Credit counter cnt, range 0..DEPTH, width clog2(DEPTH)+1:
  - +1 on a fired read.
  - -1 on a FIFO pop (`in_r_valid & in_r_ready`).
  - Simultaneous +1 and -1 leave cnt unchanged.
  - cnt never exceeds DEPTH, so the FIFO can never overflow.
- Response tracking: `rd_pend <= fire & slot_wen`.
  - When `tcdm_r_valid & rd_pend`, tcdm_r_data is pushed into the FIFO.
  - tcdm_r_valid with rd_pend = 0 (write response or spurious response) is ignored.
- FIFO: DEPTH entries, in-order, registered, no fall-through.
  - `in_r_valid = !empty`; in_r_data is the head entry.
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
  - Pop when empty is impossible, because in_r_valid = 0.
- Writes consume no credit and never produce an upstream response.
- `busy_o = slot_valid | rd_pend | !empty`.

## Timing
- Reset/clear (rst_i or clear_i high at a clock edge) sets slot_valid, rd_pend, FIFO pointers and cnt to 0.
  - Outputs during and after reset: in_gnt = 0 while rst_i/clear_i is high, 1 afterwards; tcdm_req = 0; in_r_valid = 0; busy_o = 0; data/address outputs = 0.
- Reset mid-operation discards buffered requests and responses. A TCDM response arriving in the cycle after reset is dropped because rd_pend = 0.
- Read latency with no contention:
  - in_req accepted at cycle 0.
  - tcdm_req at cycle 1, granted at cycle 1.
  - tcdm_r_valid at cycle 2.
  - in_r_valid at cycle 3.
- Throughput: 1 request/cycle per port while tcdm_gnt = 1 and cnt < DEPTH.
- Credit stall: with DEPTH reads outstanding and the FIFO unpopped, tcdm_req stays low for a pending read. It rises in the cycle after the first pop.
- Write throughput is unaffected by a full FIFO.

## Test plan
- Single read, port 0: in_add=0x100, TCDM returns 0xDEADBEEF. Required: tcdm_req at cycle 1; in_r_valid with 0xDEADBEEF at cycle 3; busy_o low at cycle 4.
- Back-to-back reads with in_r_ready=0, DEPTH=4: 6 reads issued. Required: exactly 4 TCDM grants, then tcdm_req held low. After one pop, the 5th read issues the next cycle. All 6 data values return in order.
- Write stream with in_r_ready=0 and a full FIFO: 8 writes. Required: all 8 granted at 1/cycle; no in_r_valid for writes; FIFO contents unchanged.
- tcdm_gnt held low 5 cycles, MP=3 with ports 1 and 2 streaming. Required: port 0 tcdm_req and fields stable throughout; in_gnt[0]=0; ports 1 and 2 unaffected.
- Mixed read/write/read with simultaneous push and pop on a full FIFO. Required: occupancy constant; cnt never exceeds 4; 2 read responses only.
- rst_i asserted with 3 reads in flight. Required: next cycle tcdm_req=0, in_r_valid=0, busy_o=0; a late tcdm_r_valid is not pushed. A read after reset completes normally with 3-cycle latency.
